// File: rtl/csr_regfile_if.sv
// CSR regfile bus: commit-side write/event strobes, read port, and the
// architectural state views consumed by fetch and interrupt logic.
interface csr_regfile_if #(
  parameter int DATA_W = 32
);
  logic              WEn;
  logic [13:0]       WAddr;
  logic [DATA_W-1:0] WDate;
  logic [DATA_W-1:0] WMask;
  logic [13:0]       RAddr;
  logic [DATA_W-1:0] RData;
  logic              ExcpValid;
  logic [5:0]        ExcpEcode;
  logic [DATA_W-1:0] ExcpPc;
  logic              ExcpBadvValid;
  logic [DATA_W-1:0] ExcpBadv;
  logic              ErtnValid;
  logic [7:0]        HwIntIn;
  logic [DATA_W-1:0] EentryPc;
  logic [DATA_W-1:0] EraPc;
  logic [1:0]        CrmdPlv;
  logic              CrmdIe;
  logic              IntReq;

  modport master (
    output WEn, WAddr, WDate, WMask, RAddr,
    output ExcpValid, ExcpEcode, ExcpPc, ExcpBadvValid, ExcpBadv,
    output ErtnValid, HwIntIn,
    input  RData, EentryPc, EraPc, CrmdPlv, CrmdIe, IntReq
  );

  modport slave (
    input  WEn, WAddr, WDate, WMask, RAddr,
    input  ExcpValid, ExcpEcode, ExcpPc, ExcpBadvValid, ExcpBadv,
    input  ErtnValid, HwIntIn,
    output RData, EentryPc, EraPc, CrmdPlv, CrmdIe, IntReq
  );
endinterface

// File: rtl/csr_regfile.sv
// LoongArch CSR storage: masked software writes, combinational read port,
// exception/ertn state updates, countdown timer and interrupt request.
module csr_regfile #(
  parameter int DATA_W   = 32,
  parameter int SAVE_NUM = 4,
  parameter int TIMER_W  = 32
) (
  input  logic         Clk,
  input  logic         Rest,
  csr_regfile_if.slave bus
);

  localparam logic [13:0] A_CRMD   = 14'h000;
  localparam logic [13:0] A_PRMD   = 14'h001;
  localparam logic [13:0] A_ECTL   = 14'h004;
  localparam logic [13:0] A_ESTAT  = 14'h005;
  localparam logic [13:0] A_ERA    = 14'h006;
  localparam logic [13:0] A_BADV   = 14'h007;
  localparam logic [13:0] A_EENTRY = 14'h00C;
  localparam logic [13:0] A_SAVE0  = 14'h030;
  localparam logic [13:0] A_TID    = 14'h040;
  localparam logic [13:0] A_TCFG   = 14'h041;
  localparam logic [13:0] A_TVAL   = 14'h042;
  localparam logic [13:0] A_TICLR  = 14'h044;

  localparam logic [TIMER_W-1:0] TVAL_ONE = 1;

  // Bit-masked merge shared by csrwr (all-ones mask) and csrxchg.
  function automatic logic [DATA_W-1:0] masked_wr(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] data,
    input logic [DATA_W-1:0] mask
  );
    return (old_val & ~mask) | (data & mask);
  endfunction

  logic [1:0]          crmd_plv;
  logic                crmd_ie;
  logic [1:0]          prmd_pplv;
  logic                prmd_pie;
  logic [12:0]         ectl_lie;
  logic [12:0]         estat_is;
  logic [5:0]          estat_ecode;
  logic [DATA_W-1:0]   era;
  logic [DATA_W-1:0]   badv;
  logic [DATA_W-1:7+5] eentry_hi;
  logic [11:6]         eentry_lo;
  logic [DATA_W-1:0]   save [SAVE_NUM];
  logic [DATA_W-1:0]   tid;
  logic                tcfg_en;
  logic                tcfg_per;
  logic [TIMER_W-1:2]  tcfg_init;
  logic [TIMER_W-1:0]  tval;

  logic [DATA_W-1:6]   eentry_va;
  assign eentry_va = {eentry_hi, eentry_lo};

  logic wr_crmd, wr_prmd, wr_ectl, wr_estat, wr_era, wr_badv;
  logic wr_eentry, wr_tid, wr_tcfg, ticlr_clr, timer_fire;
  logic                tcfg_en_n;
  logic                tcfg_per_n;
  logic [TIMER_W-1:2]  tcfg_init_n;
  logic [DATA_W-1:6]   eentry_va_n;
  logic [DATA_W-1:0]   rd;

  assign wr_crmd   = bus.WEn && (bus.WAddr == A_CRMD);
  assign wr_prmd   = bus.WEn && (bus.WAddr == A_PRMD);
  assign wr_ectl   = bus.WEn && (bus.WAddr == A_ECTL);
  assign wr_estat  = bus.WEn && (bus.WAddr == A_ESTAT);
  assign wr_era    = bus.WEn && (bus.WAddr == A_ERA);
  assign wr_badv   = bus.WEn && (bus.WAddr == A_BADV);
  assign wr_eentry = bus.WEn && (bus.WAddr == A_EENTRY);
  assign wr_tid    = bus.WEn && (bus.WAddr == A_TID);
  assign wr_tcfg   = bus.WEn && (bus.WAddr == A_TCFG);
  assign ticlr_clr = bus.WEn && (bus.WAddr == A_TICLR) && bus.WDate[0] && bus.WMask[0];

  // A TCFG write restarts the countdown, so the timer only expires when TCFG is untouched.
  assign timer_fire = tcfg_en && !wr_tcfg && (tval == '0);

  // Post-write values of fields that feed more than one register.
  always_comb begin
    tcfg_en_n   = 1'(masked_wr(DATA_W'(tcfg_en), bus.WDate, bus.WMask));
    tcfg_per_n  = 1'(masked_wr(DATA_W'(tcfg_per), bus.WDate >> 1, bus.WMask >> 1));
    tcfg_init_n = (TIMER_W-2)'(masked_wr(DATA_W'(tcfg_init), bus.WDate >> 2, bus.WMask >> 2));
    eentry_va_n = (DATA_W-6)'(masked_wr(DATA_W'(eentry_va), bus.WDate >> 6, bus.WMask >> 6));
  end

  // Trap-related state: exception beats ertn beats software writes.
  always_ff @(posedge Clk) begin
    if (!Rest) begin
      crmd_plv    <= '0;
      crmd_ie     <= 1'b0;
      prmd_pplv   <= '0;
      prmd_pie    <= 1'b0;
      era         <= '0;
      badv        <= '0;
      estat_ecode <= '0;
    end else if (bus.ExcpValid) begin
      prmd_pplv   <= crmd_plv;
      prmd_pie    <= crmd_ie;
      crmd_plv    <= 2'b00;
      crmd_ie     <= 1'b0;
      era         <= bus.ExcpPc;
      estat_ecode <= bus.ExcpEcode;
      if (bus.ExcpBadvValid) badv <= bus.ExcpBadv;
    end else if (bus.ErtnValid) begin
      crmd_plv <= prmd_pplv;
      crmd_ie  <= prmd_pie;
    end else begin
      if (wr_crmd) {crmd_ie, crmd_plv} <= 3'(masked_wr(DATA_W'({crmd_ie, crmd_plv}), bus.WDate, bus.WMask));
      if (wr_prmd) {prmd_pie, prmd_pplv} <= 3'(masked_wr(DATA_W'({prmd_pie, prmd_pplv}), bus.WDate, bus.WMask));
      if (wr_era)  era  <= masked_wr(era, bus.WDate, bus.WMask);
      if (wr_badv) badv <= masked_wr(badv, bus.WDate, bus.WMask);
    end
  end

  // Plain software-only registers, unaffected by exceptions.
  always_ff @(posedge Clk) begin
    if (!Rest) begin
      ectl_lie  <= '0;
      eentry_hi <= '0;
      eentry_lo <= '0;
      tid       <= '0;
      for (int i = 0; i < SAVE_NUM; i++) save[i] <= '0;
    end else begin
      if (wr_ectl)   ectl_lie <= 13'(masked_wr(DATA_W'(ectl_lie), bus.WDate, bus.WMask));
      if (wr_eentry) {eentry_hi, eentry_lo} <= eentry_va_n;
      if (wr_tid)    tid <= masked_wr(tid, bus.WDate, bus.WMask);
      for (int i = 0; i < SAVE_NUM; i++) begin
        if (bus.WEn && (bus.WAddr == A_SAVE0 + 14'(i))) save[i] <= masked_wr(save[i], bus.WDate, bus.WMask);
      end
    end
  end

  // Timer countdown and interrupt status; expiry wins over a same-cycle TICLR.
  always_ff @(posedge Clk) begin
    if (!Rest) begin
      tcfg_en   <= 1'b0;
      tcfg_per  <= 1'b0;
      tcfg_init <= '0;
      tval      <= '0;
      estat_is  <= '0;
    end else begin
      if (wr_tcfg) begin
        tcfg_en   <= tcfg_en_n;
        tcfg_per  <= tcfg_per_n;
        tcfg_init <= tcfg_init_n;
        tval      <= {tcfg_init_n, 2'b00};
      end else if (tcfg_en) begin
        if (tval != '0)    tval    <= tval - TVAL_ONE;
        else if (tcfg_per) tval    <= {tcfg_init, 2'b00};
        else               tcfg_en <= 1'b0;
      end
      if (wr_estat) estat_is[1:0] <= 2'(masked_wr(DATA_W'(estat_is[1:0]), bus.WDate, bus.WMask));
      estat_is[9:2] <= bus.HwIntIn;
      estat_is[10]  <= 1'b0;
      estat_is[12]  <= 1'b0;
      if (timer_fire)     estat_is[11] <= 1'b1;
      else if (ticlr_clr) estat_is[11] <= 1'b0;
    end
  end

  // Read port: pre-write register state, unimplemented bits and addresses read 0.
  always_comb begin
    rd = '0;
    case (bus.RAddr)
      A_CRMD:   rd[2:0] = {crmd_ie, crmd_plv};
      A_PRMD:   rd[2:0] = {prmd_pie, prmd_pplv};
      A_ECTL:   rd[12:0] = ectl_lie;
      A_ESTAT:  begin
        rd[12:0]  = estat_is;
        rd[21:16] = estat_ecode;
      end
      A_ERA:    rd = era;
      A_BADV:   rd = badv;
      A_EENTRY: rd = {eentry_va, 6'b000000};
      A_TID:    rd = tid;
      A_TCFG:   rd[TIMER_W-1:0] = {tcfg_init, tcfg_per, tcfg_en};
      A_TVAL:   rd[TIMER_W-1:0] = tval;
      default:  rd = '0;
    endcase
    for (int i = 0; i < SAVE_NUM; i++) begin
      if (bus.RAddr == A_SAVE0 + 14'(i)) rd = save[i];
    end
  end

  assign bus.RData    = rd;
  assign bus.EentryPc = {eentry_va, 6'b000000};
  assign bus.EraPc    = era;
  assign bus.CrmdPlv  = crmd_plv;
  assign bus.CrmdIe   = crmd_ie;
  assign bus.IntReq   = crmd_ie & (|(estat_is & ectl_lie));

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: an architectural CSR model (address-indexed
// table with per-address writable masks) is compared every cycle against the
// DUT, and literal expectations along the way pin the model.
module tb_csr_regfile;
  localparam int DW = 32;
  localparam int SN = 4;
  localparam int TW = 32;

  logic Clk = 1'b0;
  logic Rest = 1'b0;
  bit   cmp_en = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 Clk = ~Clk;

  csr_regfile_if #(.DATA_W(DW)) bus ();

  csr_regfile #(.DATA_W(DW), .SAVE_NUM(SN), .TIMER_W(TW)) dut (
    .Clk  (Clk),
    .Rest (Rest),
    .bus  (bus)
  );

  // ---------------- architectural model ----------------
  logic [31:0] m  [0:511] = '{default: 32'h0};
  logic [31:0] nx [0:511];

  function automatic bit impl(input logic [13:0] a);
    if (a inside {14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007,
                  14'h00C, 14'h040, 14'h041, 14'h042, 14'h044}) return 1'b1;
    return (a >= 14'h030) && (a < 14'h030 + 14'(SN));
  endfunction

  function automatic logic [31:0] sw_mask(input logic [13:0] a);
    case (a)
      14'h000, 14'h001: return 32'h0000_0007;
      14'h004:          return 32'h0000_1FFF;
      14'h005:          return 32'h0000_0003;
      14'h00C:          return 32'hFFFF_FFC0;
      14'h042, 14'h044: return 32'h0;
      default:          return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] model_rd(input logic [13:0] a);
    if (!impl(a)) return 32'h0;
    return m[a[8:0]];
  endfunction

  always @(posedge Clk) begin : model
    logic [13:0] a;
    logic [31:0] k;
    bit          tw, fire, blocked;
    nx = m;
    if (!Rest) begin
      foreach (nx[i]) nx[i] = 32'h0;
    end else begin
      a  = bus.WAddr;
      tw = bus.WEn && (a == 14'h041);
      blocked = (bus.ExcpValid || bus.ErtnValid) && (a inside {14'h000, 14'h001, 14'h006, 14'h007});
      if (bus.WEn && impl(a) && !blocked) begin
        k = sw_mask(a) & bus.WMask;
        nx[a[8:0]] = (m[a[8:0]] & ~k) | (bus.WDate & k);
      end
      if (tw) nx[9'h042] = nx[9'h041] & 32'hFFFF_FFFC;
      fire = !tw && m[9'h041][0] && (m[9'h042] == 0);
      if (!tw && m[9'h041][0]) begin
        if (m[9'h042] != 0)     nx[9'h042] = m[9'h042] - 1;
        else if (m[9'h041][1])  nx[9'h042] = m[9'h041] & 32'hFFFF_FFFC;
        else                    nx[9'h041][0] = 1'b0;
      end
      if (fire) nx[9'h005][11] = 1'b1;
      else if (bus.WEn && a == 14'h044 && bus.WDate[0] && bus.WMask[0]) nx[9'h005][11] = 1'b0;
      nx[9'h005][9:2] = bus.HwIntIn;
      if (bus.ExcpValid) begin
        nx[9'h001][2:0]   = m[9'h000][2:0];
        nx[9'h000][2:0]   = 3'b000;
        nx[9'h006]        = bus.ExcpPc;
        nx[9'h005][21:16] = bus.ExcpEcode;
        if (bus.ExcpBadvValid) nx[9'h007] = bus.ExcpBadv;
      end else if (bus.ErtnValid) begin
        nx[9'h000][2:0] = m[9'h001][2:0];
      end
    end
    m = nx;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      check("cmp_rdata",  bus.RData, model_rd(bus.RAddr));
      check("cmp_eentry", bus.EentryPc, m[9'h00C]);
      check("cmp_era",    bus.EraPc, m[9'h006]);
      check("cmp_plv",    bus.CrmdPlv, m[9'h000][1:0]);
      check("cmp_ie",     bus.CrmdIe, m[9'h000][2]);
      check("cmp_intreq", bus.IntReq, m[9'h000][2] & (|(m[9'h005][12:0] & m[9'h004][12:0])));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge Clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [13:0] a, input logic [31:0] exp);
    bus.RAddr = a;
    #1;
    check(name, bus.RData, exp);
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] mk);
    bus.WEn = 1'b1; bus.WAddr = a; bus.WDate = d; bus.WMask = mk;
    cyc();
    bus.WEn = 1'b0;
  endtask

  initial begin
    bus.WEn = 0; bus.WAddr = '0; bus.WDate = '0; bus.WMask = '0; bus.RAddr = '0;
    bus.ExcpValid = 0; bus.ExcpEcode = '0; bus.ExcpPc = '0; bus.ExcpBadvValid = 0;
    bus.ExcpBadv = '0; bus.ErtnValid = 0; bus.HwIntIn = '0;
    repeat (3) cyc();
    cmp_en = 1'b1;
    Rest = 1'b1;

    // reset state across the whole address window
    check("rst_plv", bus.CrmdPlv, 2'd0);
    check("rst_intreq", bus.IntReq, 1'b0);
    check("rst_eentry", bus.EentryPc, 32'h0);
    for (int a = 0; a <= 'h181; a++) begin
      lit("rst_rdata", 14'(a), 32'h0);
      cyc();
    end

    // csrxchg and out-of-range SAVE index
    wr(14'h030, 32'hFFFF_0000, 32'hFFFF_FFFF);
    wr(14'h030, 32'h0000_1234, 32'h0000_FFFF);
    lit("xchg_save0", 14'h030, 32'hFFFF_1234);
    wr(14'h030 + 14'(SN), 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    lit("save_oob", 14'h030 + 14'(SN), 32'h0);

    // periodic timer with interrupt enabled
    wr(14'h004, 32'h0000_0810, 32'hFFFF_FFFF);
    wr(14'h000, 32'h0000_0004, 32'hFFFF_FFFF);
    wr(14'h041, 32'h0000_000B, 32'hFFFF_FFFF);
    lit("tval_load", 14'h042, 32'd8);
    for (int v = 7; v >= 0; v--) begin
      cyc();
      lit("tval_dn", 14'h042, 32'(v));
    end
    cyc();
    lit("tmr_is11", 14'h005, 32'h0000_0800);
    lit("tval_reload", 14'h042, 32'd8);
    check("tmr_intreq", bus.IntReq, 1'b1);
    wr(14'h044, 32'h1, 32'hFFFF_FFFF);
    lit("ticlr_clr", 14'h005, 32'h0);
    lit("ticlr_tval", 14'h042, 32'd7);
    check("ticlr_intreq", bus.IntReq, 1'b0);
    repeat (7) cyc();
    lit("tval_zero", 14'h042, 32'd0);
    wr(14'h044, 32'h1, 32'hFFFF_FFFF);
    lit("ticlr_vs_fire", 14'h005, 32'h0000_0800);
    lit("tval_reload2", 14'h042, 32'd8);

    // one-shot timer
    wr(14'h044, 32'h1, 32'hFFFF_FFFF);
    wr(14'h041, 32'h0000_0009, 32'hFFFF_FFFF);
    lit("os_tcfg", 14'h041, 32'h9);
    repeat (8) cyc();
    lit("os_tval0", 14'h042, 32'd0);
    lit("os_is_pre", 14'h005, 32'h0);
    cyc();
    lit("os_is11", 14'h005, 32'h0000_0800);
    lit("os_en_clr", 14'h041, 32'h8);
    lit("os_hold", 14'h042, 32'd0);
    wr(14'h044, 32'h1, 32'hFFFF_FFFF);
    repeat (3) cyc();
    lit("os_once", 14'h005, 32'h0);
    lit("os_hold2", 14'h042, 32'd0);

    // exception with a dropped same-cycle CRMD write, then ertn
    wr(14'h000, 32'h7, 32'hFFFF_FFFF);
    bus.ExcpValid = 1; bus.ExcpEcode = 6'h0B; bus.ExcpPc = 32'h1C00_0100;
    bus.ExcpBadvValid = 1; bus.ExcpBadv = 32'h0000_BAD0;
    wr(14'h000, 32'h3, 32'hFFFF_FFFF);
    bus.ExcpValid = 0; bus.ExcpBadvValid = 0;
    check("excp_plv", bus.CrmdPlv, 2'd0);
    check("excp_era", bus.EraPc, 32'h1C00_0100);
    lit("excp_prmd", 14'h001, 32'h7);
    lit("excp_crmd", 14'h000, 32'h0);
    lit("excp_estat", 14'h005, 32'h000B_0000);
    cyc();
    lit("excp_badv", 14'h007, 32'h0000_BAD0);
    bus.ErtnValid = 1;
    wr(14'h001, 32'h0, 32'hFFFF_FFFF);
    bus.ErtnValid = 0;
    lit("ertn_crmd", 14'h000, 32'h7);
    lit("ertn_prmd_keep", 14'h001, 32'h7);

    // hardware interrupt line, software IS bits, IE masking
    bus.HwIntIn = 8'h04;
    cyc();
    check("hw_intreq", bus.IntReq, 1'b1);
    lit("hw_is4", 14'h005, 32'h000B_0010);
    wr(14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    lit("estat_sw", 14'h005, 32'h000B_0013);
    wr(14'h000, 32'h3, 32'hFFFF_FFFF);
    check("ie_off_intreq", bus.IntReq, 1'b0);
    check("ie_off_plv", bus.CrmdPlv, 2'd3);
    wr(14'h00C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("eentry_pc", bus.EentryPc, 32'hFFFF_FFC0);

    // reset mid-countdown
    bus.HwIntIn = 8'h00;
    wr(14'h041, 32'h0000_000B, 32'hFFFF_FFFF);
    repeat (3) cyc();
    Rest = 1'b0;
    cyc();
    Rest = 1'b1;
    lit("rst2_tval", 14'h042, 32'h0);
    lit("rst2_tcfg", 14'h041, 32'h0);
    check("rst2_eentry", bus.EentryPc, 32'h0);
    cyc();
    lit("rst2_tval_hold", 14'h042, 32'h0);
    lit("rst2_save0", 14'h030, 32'h0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
